// File: rtl/sap1_pcore.sv
// SAP-1 style processor core: 16-word program memory, accumulator machine
// with a six-state ring counter and a LOAD/RUN/HALT mode FSM.
// Optional feature: define SAP1_VARCYC_EN to end short instructions after T4
// instead of always spending six T-states per instruction.
module sap1_pcore #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              Clk,
    input  logic              Clr,
    input  logic              start,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic              HLT,
    output logic [DATA_W-1:0] LEDOUT,
    output logic [11:0]       CONTWORD,
    output logic              busy,
    output logic              zflag,
    output logic              cflag
);

    typedef enum logic [1:0] {LOAD, RUN, HALT} mode_t;

    // Control words, bits 11..0 = Cp Ep nLm nCE nLi nEi nLa Ea Su Eu nLb nLo
    localparam logic [11:0] CW_IDLE = 12'h3E3;
    localparam logic [11:0] CW_T1   = 12'h5E3;
    localparam logic [11:0] CW_T2   = 12'hBE3;
    localparam logic [11:0] CW_T3   = 12'h263;
    localparam logic [11:0] CW_MARI = 12'h1A3;  // MAR <= IR operand
    localparam logic [11:0] CW_LDA5 = 12'h2C3;  // A <= RAM
    localparam logic [11:0] CW_LDB5 = 12'h2E1;  // B <= RAM
    localparam logic [11:0] CW_ADD6 = 12'h3C7;  // A <= A + B
    localparam logic [11:0] CW_SUB6 = 12'h3CF;  // A <= A - B
    localparam logic [11:0] CW_LDI  = 12'h383;  // A <= IR operand
    localparam logic [11:0] CW_JMP  = 12'h3A3;  // PC <= IR operand
    localparam logic [11:0] CW_STA5 = 12'h3F3;  // RAM <= A
    localparam logic [11:0] CW_OUT  = 12'h3F2;  // OUT <= A

    mode_t             mode, mode_nxt;
    logic [5:0]        ring, ring_nxt;   // one-hot T1..T6, bit 0 = T1
    logic [ADDR_W-1:0] pc, mar;
    logic [DATA_W-1:0] acc, breg, ir;
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [3:0]        opcode;
    logic [ADDR_W-1:0] operand;
    logic              long_op, last_t;
    logic [DATA_W:0]   alu_res;

    // {carry, result}; for subtraction the carry is "no borrow" (a >= b)
    function automatic logic [DATA_W:0] alu(input logic sub,
                                            input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b);
        logic [DATA_W:0] r;
        if (sub) begin
            r[DATA_W-1:0] = a - b;
            r[DATA_W]     = (a >= b);
        end else begin
            r = {1'b0, a} + {1'b0, b};
        end
        return r;
    endfunction

    assign opcode  = ir[DATA_W-1 -: 4];
    assign operand = ir[ADDR_W-1:0];
    assign long_op = (opcode <= 4'h3);
    assign alu_res = alu(opcode == 4'h2, acc, breg);
    assign HLT     = (mode == HALT);
    assign busy    = (mode == RUN);

`ifdef SAP1_VARCYC_EN
    assign last_t = ring[5] | (ring[3] & ~long_op);
`else
    assign last_t = ring[5];
`endif

    // Mode and ring-counter state registers
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            mode <= LOAD;
            ring <= 6'b000001;
        end else begin
            mode <= mode_nxt;
            ring <= ring_nxt;
        end
    end

    // Next mode/T-state and the control word for the current T-state.
    // The start edge doubles as T1 of the first fetch, so RUN begins in T2.
    always_comb begin
        mode_nxt = mode;
        ring_nxt = ring;
        CONTWORD = CW_IDLE;
        case (mode)
            LOAD: begin
                if (start) begin
                    mode_nxt = RUN;
                    ring_nxt = 6'b000010;
                end
            end
            RUN: begin
                ring_nxt = last_t ? 6'b000001 : {ring[4:0], 1'b0};
                if (ring[3] && opcode == 4'hF) begin
                    mode_nxt = HALT;
                    ring_nxt = 6'b000001;
                end
                if (ring[0]) CONTWORD = CW_T1;
                else if (ring[1]) CONTWORD = CW_T2;
                else if (ring[2]) CONTWORD = CW_T3;
                else if (ring[3]) begin
                    case (opcode)
                        4'h0, 4'h1, 4'h2, 4'h3: CONTWORD = CW_MARI;
                        4'h4: CONTWORD = CW_LDI;
                        4'h5: CONTWORD = CW_JMP;
                        4'h6: CONTWORD = zflag ? CW_JMP : CW_IDLE;
                        4'h7: CONTWORD = cflag ? CW_JMP : CW_IDLE;
                        4'hE: CONTWORD = CW_OUT;
                        default: CONTWORD = CW_IDLE;
                    endcase
                end else if (ring[4]) begin
                    case (opcode)
                        4'h0: CONTWORD = CW_LDA5;
                        4'h1, 4'h2: CONTWORD = CW_LDB5;
                        4'h3: CONTWORD = CW_STA5;
                        default: CONTWORD = CW_IDLE;
                    endcase
                end else if (ring[5]) begin
                    case (opcode)
                        4'h1: CONTWORD = CW_ADD6;
                        4'h2: CONTWORD = CW_SUB6;
                        default: CONTWORD = CW_IDLE;
                    endcase
                end
            end
            HALT: begin
                ring_nxt = 6'b000001;
            end
            default: begin
                mode_nxt = LOAD;
                ring_nxt = 6'b000001;
            end
        endcase
    end

    // Register-transfer actions taken on the edge that ends each T-state
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            pc     <= '0;
            mar    <= '0;
            acc    <= '0;
            breg   <= '0;
            ir     <= '0;
            LEDOUT <= '0;
            zflag  <= 1'b0;
            cflag  <= 1'b0;
        end else if (mode == LOAD) begin
            if (start) mar <= pc;
        end else if (mode == RUN) begin
            if (ring[0]) mar <= pc;
            if (ring[1]) pc <= pc + ADDR_W'(1);
            if (ring[2]) ir <= mem[mar];
            if (ring[3]) begin
                case (opcode)
                    4'h0, 4'h1, 4'h2, 4'h3: mar <= operand;
                    4'h4: acc <= DATA_W'(operand);
                    4'h5: pc <= operand;
                    4'h6: if (zflag) pc <= operand;
                    4'h7: if (cflag) pc <= operand;
                    4'hE: LEDOUT <= acc;
                    default: ;
                endcase
            end
            if (ring[4]) begin
                if (opcode == 4'h0) acc <= mem[mar];
                if (opcode == 4'h1 || opcode == 4'h2) breg <= mem[mar];
            end
            if (ring[5] && (opcode == 4'h1 || opcode == 4'h2)) begin
                acc   <= alu_res[DATA_W-1:0];
                cflag <= alu_res[DATA_W];
                zflag <= (alu_res[DATA_W-1:0] == '0);
            end
        end
    end

    // Program memory: loader writes in LOAD, STA writes at T5 in RUN; never cleared
    always_ff @(posedge Clk) begin
        if (mode == LOAD && prog_we)
            mem[prog_addr] <= prog_data;
        else if (mode == RUN && ring[4] && opcode == 4'h3)
            mem[mar] <= acc;
    end

endmodule

// File: tb/tb_sap1_pcore.sv
// Directed bench for sap1_pcore: table of whole programs with their expected
// final outputs and halt latency, plus hand-written multi-cycle sequences.
module tb_sap1_pcore;

`ifdef SAP1_VARCYC_EN
    localparam bit VARCYC = 1'b1;
`else
    localparam bit VARCYC = 1'b0;
`endif

    logic       Clk = 1'b0;
    logic       Clr = 1'b1;
    logic       start = 1'b0;
    logic       prog_we = 1'b0;
    logic [3:0] prog_addr = '0;
    logic [7:0] prog_data = '0;
    logic       HLT;
    logic [7:0] LEDOUT;
    logic [11:0] CONTWORD;
    logic       busy, zflag, cflag;

    int passed = 0;
    int total  = 0;

    sap1_pcore #(.DATA_W(8), .ADDR_W(4)) dut (
        .Clk(Clk), .Clr(Clr), .start(start), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_data(prog_data), .HLT(HLT),
        .LEDOUT(LEDOUT), .CONTWORD(CONTWORD), .busy(busy),
        .zflag(zflag), .cflag(cflag)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        string            name;
        logic [15:0][7:0] prog;
        logic [7:0]       led;
        logic             z;
        logic             c;
        int               edges;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        else
            passed++;
    endtask

    task automatic do_clr();
        @(negedge Clk); Clr = 1'b1;
        @(negedge Clk); Clr = 1'b0;
    endtask

    task automatic load_prog(input logic [15:0][7:0] p);
        for (int i = 0; i < 16; i++) begin
            @(negedge Clk);
            prog_we = 1'b1; prog_addr = 4'(i); prog_data = p[i];
        end
        @(negedge Clk); prog_we = 1'b0;
    endtask

    task automatic start_run();
        @(negedge Clk); start = 1'b1;
        @(negedge Clk); start = 1'b0;
    endtask

    task automatic wait_halt(input int budget, output int n);
        n = 0;
        while (!HLT && n < budget) begin
            @(negedge Clk);
            n++;
        end
    endtask

    logic [11:0] exp_cw [12];
    int n;
    int k;

    initial begin
        // ---- program table ----
        foreach (vecs[i]) vecs[i].prog = '0;
        vecs[0].name = "p029_add_out";
        vecs[0].prog[0] = 8'h09; vecs[0].prog[1] = 8'h1A; vecs[0].prog[2] = 8'hE0;
        vecs[0].prog[3] = 8'hF0; vecs[0].prog[9] = 8'h10; vecs[0].prog[10] = 8'h14;
        vecs[0].led = 8'h24; vecs[0].z = 0; vecs[0].c = 0; vecs[0].edges = VARCYC ? 19 : 21;

        vecs[1].name = "p030_carry_zero";
        vecs[1].prog[0] = 8'h0D; vecs[1].prog[1] = 8'h1E; vecs[1].prog[2] = 8'hE0;
        vecs[1].prog[3] = 8'h2F; vecs[1].prog[4] = 8'hE0; vecs[1].prog[5] = 8'hF0;
        vecs[1].prog[13] = 8'hF0; vecs[1].prog[14] = 8'h20; vecs[1].prog[15] = 8'h10;
        vecs[1].led = 8'h00; vecs[1].z = 1; vecs[1].c = 1; vecs[1].edges = VARCYC ? 29 : 33;

        vecs[2].name = "p031_pc_wrap";
        vecs[2].prog[0] = 8'h0E; vecs[2].prog[1] = 8'h67; vecs[2].prog[2] = 8'h5F;
        vecs[2].prog[7] = 8'hF0; vecs[2].prog[14] = 8'hF0; vecs[2].prog[15] = 8'h30;
        vecs[2].led = 8'h00; vecs[2].z = 0; vecs[2].c = 0; vecs[2].edges = VARCYC ? 23 : 27;

        vecs[3].name = "ldi_jz_jc_taken";
        vecs[3].prog[0] = 8'h45; vecs[3].prog[1] = 8'h2C; vecs[3].prog[2] = 8'h66;
        vecs[3].prog[3] = 8'hF0; vecs[3].prog[6] = 8'h78; vecs[3].prog[7] = 8'hF0;
        vecs[3].prog[8] = 8'h49; vecs[3].prog[9] = 8'hE0; vecs[3].prog[10] = 8'hF0;
        vecs[3].prog[12] = 8'h05;
        vecs[3].led = 8'h09; vecs[3].z = 1; vecs[3].c = 1; vecs[3].edges = VARCYC ? 29 : 39;

        vecs[4].name = "sta_self_modify";
        vecs[4].prog[0] = 8'h0D; vecs[4].prog[1] = 8'h31; vecs[4].prog[2] = 8'h51;
        vecs[4].prog[13] = 8'hF0;
        vecs[4].led = 8'h00; vecs[4].z = 0; vecs[4].c = 0; vecs[4].edges = VARCYC ? 19 : 21;

        exp_cw = '{12'hBE3, 12'h263, 12'h1A3, 12'h2C3, 12'h3E3, 12'h5E3,
                   12'hBE3, 12'h263, 12'h1A3, 12'h2E1, 12'h3C7, 12'h5E3};

        // ---- reset state ----
        #1;
        chk("rst_hlt", HLT, 0);
        chk("rst_busy", busy, 0);
        chk("rst_led", LEDOUT, 0);
        chk("rst_cw", CONTWORD, 12'h3E3);
        chk("rst_z", zflag, 0);
        chk("rst_c", cflag, 0);
        @(negedge Clk); Clr = 1'b0;

        // ---- table-driven program runs ----
        foreach (vecs[i]) begin
            do_clr();
            load_prog(vecs[i].prog);
            start_run();
            wait_halt(200, n);
            chk({vecs[i].name, "_edges"}, n, vecs[i].edges);
            chk({vecs[i].name, "_hlt"}, HLT, 1);
            chk({vecs[i].name, "_led"}, LEDOUT, vecs[i].led);
            chk({vecs[i].name, "_z"}, zflag, vecs[i].z);
            chk({vecs[i].name, "_c"}, cflag, vecs[i].c);
        end

        // ---- control-word trace across the first instructions ----
        do_clr();
        load_prog(vecs[0].prog);
        start_run();
        chk("cw_busy", busy, 1);
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("cw_seq%0d", i), CONTWORD, exp_cw[i]);
            @(negedge Clk);
        end
        wait_halt(200, n);
        chk("cw_halt_idle", CONTWORD, 12'h3E3);
        chk("cw_halt_busy", busy, 0);

        // ---- intermediate flags after ADD overflow ----
        do_clr();
        load_prog(vecs[1].prog);
        start_run();
        k = 0;
        while (LEDOUT !== 8'h10 && k < 100) begin @(negedge Clk); k++; end
        chk("add_ovf_led", LEDOUT, 8'h10);
        chk("add_ovf_c", cflag, 1);
        chk("add_ovf_z", zflag, 0);

        // ---- Clr in T5 of ADD, rerun without reload ----
        do_clr();
        load_prog(vecs[0].prog);
        start_run();
        k = 0;
        while (CONTWORD !== 12'h2E1 && k < 50) begin @(negedge Clk); k++; end
        chk("clr_found_add_t5", CONTWORD, 12'h2E1);
        Clr = 1'b1;
        #1;
        chk("clr_hlt", HLT, 0);
        chk("clr_busy", busy, 0);
        chk("clr_led", LEDOUT, 0);
        chk("clr_cw", CONTWORD, 12'h3E3);
        chk("clr_zc", {zflag, cflag}, 0);
        @(negedge Clk); Clr = 1'b0;
        start_run();
        wait_halt(200, n);
        chk("clr_rerun_edges", n, VARCYC ? 19 : 21);
        chk("clr_rerun_led", LEDOUT, 8'h24);

        // ---- prog_we and start ignored during RUN and HALT ----
        do_clr();
        start_run();
        n = 0;
        while (!HLT && n < 200) begin
            prog_we = (n == 2 || n == 8);
            prog_addr = (n == 2) ? 4'h9 : 4'hA;
            prog_data = (n == 2) ? 8'hFF : 8'h00;
            start = (n == 5);
            @(negedge Clk);
            n++;
        end
        prog_we = 1'b0; start = 1'b0;
        chk("run_we_edges", n, VARCYC ? 19 : 21);
        chk("run_we_led", LEDOUT, 8'h24);
        prog_we = 1'b1; prog_addr = 4'h9; prog_data = 8'h00; start = 1'b1;
        @(negedge Clk);
        prog_we = 1'b0; start = 1'b0;
        @(negedge Clk);
        chk("halt_start_hlt", HLT, 1);
        chk("halt_start_busy", busy, 0);
        do_clr();
        start_run();
        wait_halt(200, n);
        chk("halt_we_rerun_led", LEDOUT, 8'h24);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
